// File: rtl/cu_accum_if.sv
// Handshake bundle between the PE array, cu_accum and the result consumer.
// Beats flow in on pe_out/in_valid/in_ready; results leave on out_*.
interface cu_accum_if #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned NUM_PE = 9,
  parameter int unsigned ACC_W  = 28,
  parameter int unsigned OUT_W  = 8
);
  logic [NUM_PE*PROD_W-1:0] pe_out;
  logic                     in_valid;
  logic                     in_ready;
  logic [7:0]               num_ch;
  logic [4:0]               shift;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         out_data;
  logic [ACC_W-1:0]         out_acc;
  logic                     busy;

  modport master (
    output pe_out, in_valid, num_ch, shift, out_ready,
    input  in_ready, out_valid, out_data, out_acc, busy
  );

  modport slave (
    input  pe_out, in_valid, num_ch, shift, out_ready,
    output in_ready, out_valid, out_data, out_acc, busy
  );
endinterface

// File: rtl/cu_accum.sv
// Convolution back end: adder tree over nine PE products, multi-channel
// accumulation, shift/saturate requantization and a small FWFT result FIFO.
module cu_accum #(
  parameter int unsigned PROD_W     = 16,
  parameter int unsigned NUM_PE     = 9,
  parameter int unsigned ACC_W      = 28,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  cu_accum_if.slave bus
);

  localparam int unsigned GRP     = NUM_PE / 3;
  localparam int unsigned PS_W    = PROD_W + 2;
  localparam int unsigned SUM_W   = PROD_W + 4;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned WORD_W  = ACC_W + OUT_W;
  localparam int unsigned OUT_MAX = (1 << OUT_W) - 1;

  // channel counter and per-group captured settings
  logic [7:0]        cnt, cnt_nx;
  logic [7:0]        cap_num, cap_num_nx;
  logic [4:0]        cap_shift, cap_shift_nx;

  // S1: partial sums
  logic [PS_W-1:0]   s1_ps [GRP];
  logic [PS_W-1:0]   s1_ps_nx [GRP];
  logic              s1_vld, s1_first, s1_last;
  logic              s1_vld_nx, s1_first_nx, s1_last_nx;
  logic [4:0]        s1_shift, s1_shift_nx;

  // S2: beat sum
  logic [SUM_W-1:0]  s2_sum, s2_sum_nx;
  logic              s2_vld, s2_first, s2_last;
  logic              s2_vld_nx;
  logic [4:0]        s2_shift;

  // ACC stage
  logic [ACC_W-1:0]  acc, acc_nx;
  logic              acc_vld;

  // result FIFO
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_nx, rd_ptr, rd_ptr_nx;
  logic [CNT_W-1:0]  count, count_nx;
  logic [WORD_W-1:0] push_word_c, head_nx;

  logic              in_ready_q, in_ready_nx;
  logic              out_valid_q, out_valid_nx;
  logic [OUT_W-1:0]  out_data_q;
  logic [ACC_W-1:0]  out_acc_q;
  logic              busy_q, busy_nx;

  logic              accept_c, first_c, last_c, push_c, pop_c;
  logic [7:0]        eff_num_c;
  logic [4:0]        beat_shift_c;
  logic [ACC_W-1:0]  q_c;
  logic [OUT_W-1:0]  rq_c;
  logic [31:0]       pend_c;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.busy      = busy_q;

  // next-state for counter, pipeline, accumulator and FIFO
  always_comb begin
    cnt_nx       = cnt;
    cap_num_nx   = cap_num;
    cap_shift_nx = cap_shift;
    for (int g = 0; g < int'(GRP); g++) s1_ps_nx[g] = '0;
    s2_sum_nx    = '0;
    acc_nx       = acc;

    accept_c     = bus.in_valid && in_ready_q;
    first_c      = (cnt == 8'd0);
    eff_num_c    = first_c ? ((bus.num_ch == 8'd0) ? 8'd1 : bus.num_ch) : cap_num;
    last_c       = (cnt == eff_num_c - 8'd1);
    beat_shift_c = first_c ? bus.shift : cap_shift;

    if (accept_c) begin
      if (first_c) begin
        cap_num_nx   = eff_num_c;
        cap_shift_nx = bus.shift;
      end
      cnt_nx = last_c ? 8'd0 : cnt + 8'd1;
    end

    s1_vld_nx   = accept_c;
    s1_first_nx = first_c;
    s1_last_nx  = last_c;
    s1_shift_nx = beat_shift_c;
    for (int g = 0; g < int'(GRP); g++) begin
      for (int k = 0; k < 3; k++) begin
        s1_ps_nx[g] = s1_ps_nx[g] + PS_W'(bus.pe_out[(3*g+k)*int'(PROD_W) +: PROD_W]);
      end
    end

    s2_vld_nx = s1_vld;
    for (int g = 0; g < int'(GRP); g++) s2_sum_nx = s2_sum_nx + SUM_W'(s1_ps[g]);

    if (s2_vld) acc_nx = s2_first ? ACC_W'(s2_sum) : acc + ACC_W'(s2_sum);

    q_c         = acc_nx >> s2_shift;
    rq_c        = (q_c > ACC_W'(OUT_MAX)) ? OUT_W'(OUT_MAX) : q_c[OUT_W-1:0];
    push_word_c = {acc_nx, rq_c};
    push_c      = s2_vld && s2_last;
    pop_c       = out_valid_q && bus.out_ready;

    count_nx  = count + CNT_W'(push_c) - CNT_W'(pop_c);
    wr_ptr_nx = push_c ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_ptr_nx = pop_c  ? rd_ptr + PTR_W'(1) : rd_ptr;
    // a push landing on the new head slot bypasses the memory
    head_nx   = (push_c && (wr_ptr == rd_ptr_nx)) ? push_word_c : mem[rd_ptr_nx];

    out_valid_nx = (count_nx != '0);
    // queued plus in-flight results must never exceed the FIFO
    pend_c       = 32'(count_nx) + 32'(s1_vld_nx && s1_last_nx) + 32'(s2_vld_nx && s1_last);
    in_ready_nx  = pend_c < FIFO_DEPTH;
    busy_nx      = (cnt_nx != 8'd0) || s1_vld_nx || s2_vld_nx || s2_vld;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      cap_num     <= '0;
      cap_shift   <= '0;
      for (int g = 0; g < int'(GRP); g++) s1_ps[g] <= '0;
      s1_vld      <= 1'b0;
      s1_first    <= 1'b0;
      s1_last     <= 1'b0;
      s1_shift    <= '0;
      s2_sum      <= '0;
      s2_vld      <= 1'b0;
      s2_first    <= 1'b0;
      s2_last     <= 1'b0;
      s2_shift    <= '0;
      acc         <= '0;
      acc_vld     <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_acc_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      cnt         <= cnt_nx;
      cap_num     <= cap_num_nx;
      cap_shift   <= cap_shift_nx;
      s1_ps       <= s1_ps_nx;
      s1_vld      <= s1_vld_nx;
      s1_first    <= s1_first_nx;
      s1_last     <= s1_last_nx;
      s1_shift    <= s1_shift_nx;
      s2_sum      <= s2_sum_nx;
      s2_vld      <= s2_vld_nx;
      s2_first    <= s1_first;
      s2_last     <= s1_last;
      s2_shift    <= s1_shift;
      acc         <= acc_nx;
      acc_vld     <= s2_vld;
      if (push_c) mem[wr_ptr] <= push_word_c;
      wr_ptr      <= wr_ptr_nx;
      rd_ptr      <= rd_ptr_nx;
      count       <= count_nx;
      in_ready_q  <= in_ready_nx;
      out_valid_q <= out_valid_nx;
      out_data_q  <= head_nx[OUT_W-1:0];
      out_acc_q   <= head_nx[WORD_W-1:OUT_W];
      busy_q      <= busy_nx;
    end
  end

  // ACC-stage valid is tracked for busy; keep it observable in waves
  logic acc_vld_unused;
  assign acc_vld_unused = acc_vld;

endmodule
